// File: rtl/wb_data_src_reg.sv
// Registered write-back data-source mux: picks one of NUM_SRC sources, extracts a
// byte/half/word lane, sign/zero-extends it and registers it with valid and error flags.
module wb_data_src_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [SEL_WIDTH-1:0]          sel,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  input  logic [1:0]                    size_mode,
  input  logic                          sign_ext,
  input  logic [1:0]                    byte_off,
  input  logic                          in_valid,
  input  logic                          stall,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  output logic                          err
);

  logic                  sel_ok_s;
  logic [DATA_WIDTH-1:0] src_s;
  logic [15:0]           half_s;
  logic [7:0]            byte_s;
  logic [DATA_WIDTH-1:0] lane_s;
  logic                  zero_s;
  logic                  err_s;

  // Source select, lane extraction, extension and legality of the current request
  always_comb begin
    sel_ok_s = (32'(sel) < 32'(NUM_SRC));
    if (sel_ok_s) begin
      src_s = src_data[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      src_s = '0;
    end

    half_s = byte_off[1] ? src_s[31:16] : src_s[15:0];
    case (byte_off)
      2'd0:    byte_s = src_s[7:0];
      2'd1:    byte_s = src_s[15:8];
      2'd2:    byte_s = src_s[23:16];
      2'd3:    byte_s = src_s[31:24];
      default: byte_s = src_s[7:0];
    endcase

    lane_s = src_s;
    zero_s = 1'b0;
    err_s  = 1'b0;
    case (size_mode)
      2'b00: lane_s = src_s;
      2'b01: begin
        lane_s = {{(DATA_WIDTH-16){sign_ext & half_s[15]}}, half_s};
        zero_s = byte_off[0];
        err_s  = byte_off[0];
      end
      2'b10: lane_s = {{(DATA_WIDTH-8){sign_ext & byte_s[7]}}, byte_s};
      default: begin
        // reserved size still forwards the word, only flags the error
        lane_s = src_s;
        err_s  = 1'b1;
      end
    endcase
    zero_s = zero_s | ~sel_ok_s;
    err_s  = err_s  | ~sel_ok_s;
  end

  // Output registers: reset > stall > in_valid
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else if (stall) begin
      out_data  <= out_data;
      out_valid <= out_valid;
      err       <= err;
    end else if (in_valid) begin
      out_data  <= zero_s ? '0 : lane_s;
      out_valid <= 1'b1;
      err       <= err_s;
    end else begin
      out_data  <= out_data;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_data_src_reg.sv
// Scoreboard bench for wb_data_src_reg: default, NUM_SRC=3 and 64-bit/6-source instances.
module tb_wb_data_src_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [1:0]   sel2;
  logic [2:0]   sel3;
  logic [127:0] src128;
  logic [383:0] src384;
  logic [1:0]   mode, off;
  logic         sx, iv, st;
  logic [31:0]  out32, out3;
  logic [63:0]  out64;
  logic         v32, e32, v3, e3, v64, e64;

  wb_data_src_reg #(.DATA_WIDTH(32), .NUM_SRC(4), .SEL_WIDTH(2)) d32 (
    .clk(clk), .reset(reset), .sel(sel2), .src_data(src128), .size_mode(mode),
    .sign_ext(sx), .byte_off(off), .in_valid(iv), .stall(st),
    .out_data(out32), .out_valid(v32), .err(e32));

  wb_data_src_reg #(.DATA_WIDTH(32), .NUM_SRC(3), .SEL_WIDTH(2)) d3 (
    .clk(clk), .reset(reset), .sel(sel2), .src_data(src128[95:0]), .size_mode(mode),
    .sign_ext(sx), .byte_off(off), .in_valid(iv), .stall(st),
    .out_data(out3), .out_valid(v3), .err(e3));

  wb_data_src_reg #(.DATA_WIDTH(64), .NUM_SRC(6), .SEL_WIDTH(3)) d64 (
    .clk(clk), .reset(reset), .sel(sel3), .src_data(src384), .size_mode(mode),
    .sign_ext(sx), .byte_off(off), .in_valid(iv), .stall(st),
    .out_data(out64), .out_valid(v64), .err(e64));

  typedef struct packed {
    logic [63:0] d;
    logic        v;
    logic        e;
  } exp_t;

  exp_t q32[$], q3[$], q64[$];
  logic [63:0] md[3];
  logic        mv[3], me[3];
  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    else pass_cnt++;
  endtask

  // Reference behaviour of one request: returns {err, data}
  function automatic logic [64:0] ref_wb(input int dw, input int ns, input int sl,
                                         input logic [63:0] s, input logic [1:0] m,
                                         input logic sgn, input logic [1:0] bo);
    logic [63:0] d;
    logic        e;
    logic [31:0] w;
    logic [15:0] h;
    logic [7:0]  b;
    w = s[31:0];
    h = bo[1] ? w[31:16] : w[15:0];
    b = 8'(w >> (8 * bo));
    e = 1'b0;
    case (m)
      2'b00: d = s;
      2'b01: begin
        d = {{48{sgn & h[15]}}, h};
        if (bo[0]) begin d = 64'h0; e = 1'b1; end
      end
      2'b10: d = {{56{sgn & b[7]}}, b};
      default: begin d = s; e = 1'b1; end
    endcase
    if (sl >= ns) begin d = 64'h0; e = 1'b1; end
    if (dw == 32) d[63:32] = 32'h0;
    return {e, d};
  endfunction

  task automatic model_upd(input int i, input int dw, input int ns, input int sl, input logic [63:0] s);
    logic [64:0] r;
    if (!st) begin
      if (iv) begin
        r = ref_wb(dw, ns, sl, s, mode, sx, off);
        md[i] = r[63:0]; mv[i] = 1'b1; me[i] = r[64];
      end else begin
        mv[i] = 1'b0; me[i] = 1'b0;
      end
    end
  endtask

  task automatic model_clr();
    for (int i = 0; i < 3; i++) begin md[i] = 64'h0; mv[i] = 1'b0; me[i] = 1'b0; end
  endtask

  // One clock: push expectations for the inputs now applied, then pop and compare
  task automatic step(input logic use_lit, input logic [31:0] ld, input logic lv, input logic le);
    exp_t x;
    logic [63:0] s64;
    model_upd(0, 32, 4, int'(sel2), {32'h0, src128[32*sel2 +: 32]});
    model_upd(1, 32, 3, int'(sel2), {32'h0, src128[32*sel2 +: 32]});
    s64 = (sel3 < 3'd6) ? src384[64*sel3 +: 64] : 64'h0;
    model_upd(2, 64, 6, int'(sel3), s64);
    if (use_lit) q32.push_back({32'h0, ld, lv, le});
    else         q32.push_back({md[0], mv[0], me[0]});
    q3.push_back({md[1], mv[1], me[1]});
    q64.push_back({md[2], mv[2], me[2]});
    @(posedge clk);
    #1;
    x = q32.pop_front();
    check_val("d32_data", 64'(out32), x.d);
    check_val("d32_valid", 64'(v32), 64'(x.v));
    check_val("d32_err", 64'(e32), 64'(x.e));
    x = q3.pop_front();
    check_val("d3_data", 64'(out3), x.d);
    check_val("d3_valid", 64'(v3), 64'(x.v));
    check_val("d3_err", 64'(e3), 64'(x.e));
    x = q64.pop_front();
    check_val("d64_data", out64, x.d);
    check_val("d64_valid", 64'(v64), 64'(x.v));
    check_val("d64_err", 64'(e64), 64'(x.e));
  endtask

  task automatic set_ctl(input logic [1:0] s, input logic [1:0] m, input logic g,
                         input logic [1:0] o, input logic v, input logic t);
    sel2 = s; mode = m; sx = g; off = o; iv = v; st = t;
  endtask

  task automatic rand_in();
    sel2 = 2'($urandom_range(0, 3));
    sel3 = 3'($urandom_range(0, 7));
    mode = 2'($urandom_range(0, 3));
    off  = 2'($urandom_range(0, 3));
    sx   = 1'($urandom_range(0, 1));
    iv   = 1'($urandom_range(0, 1));
    st   = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < 4; k++)  src128[32*k +: 32] = $urandom;
    for (int k = 0; k < 12; k++) src384[32*k +: 32] = $urandom;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_d32"}, 64'(out32), 64'h0);
    check_val({tag, "_v32"}, 64'(v32), 64'h0);
    check_val({tag, "_e32"}, 64'(e32), 64'h0);
    check_val({tag, "_d64"}, out64, 64'h0);
    check_val({tag, "_v64"}, 64'(v64), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    model_clr();
    reset = 1'b0;
    rand_in();
    // reset held with random inputs and a running clock
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rand_in();
      iv = 1'b1; st = 1'b0;
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    reset = 1'b1;
    src128 = '0; src384 = '0; sel3 = 3'd0;
    src128[63:32] = 32'hDEAD_BEEF;
    set_ctl(2'd1, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    // asynchronous reset in the middle of a cycle
    #2 reset = 1'b0;
    #1 check_zero("rst_async");
    model_clr();
    @(negedge clk);
    reset = 1'b1;

    // word path then idle
    set_ctl(2'd1, 2'b00, 1'b1, 2'd2, 1'b1, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    set_ctl(2'd1, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // byte / half extension on src0
    src128[31:0] = 32'h80F1_7F02;
    set_ctl(2'd0, 2'b10, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_007F, 1'b1, 1'b0);
    set_ctl(2'd0, 2'b10, 1'b1, 2'd3, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_FF80, 1'b1, 1'b0);
    set_ctl(2'd0, 2'b10, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0080, 1'b1, 1'b0);
    set_ctl(2'd0, 2'b01, 1'b0, 2'd2, 1'b1, 1'b0);
    step(1'b1, 32'h0000_80F1, 1'b1, 1'b0);
    set_ctl(2'd0, 2'b01, 1'b1, 2'd2, 1'b1, 1'b0);
    step(1'b1, 32'hFFFF_80F1, 1'b1, 1'b0);
    set_ctl(2'd0, 2'b01, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_7F02, 1'b1, 1'b0);

    // illegal requests
    set_ctl(2'd0, 2'b01, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b1);
    src128[95:64] = 32'h1234_5678;
    set_ctl(2'd2, 2'b11, 1'b1, 2'd1, 1'b1, 1'b0);
    step(1'b1, 32'h1234_5678, 1'b1, 1'b1);
    src128[127:96] = 32'hCAFE_F00D;
    set_ctl(2'd3, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
    check_val("sel3_ns3_data", 64'(out3), 64'h0);
    check_val("sel3_ns3_err", 64'(e3), 64'h1);
    check_val("sel3_ns3_valid", 64'(v3), 64'h1);

    // stall freezes outputs; the stalled request is dropped
    src128[31:0] = 32'h0000_00A5;
    set_ctl(2'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    src128[31:0] = 32'h0000_005A;
    for (int i = 0; i < 3; i++) begin
      set_ctl(2'd0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b1);
      step(1'b1, 32'h0000_00A5, 1'b1, 1'b0);
    end
    set_ctl(2'd0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 32'h0000_00A5, 1'b0, 1'b0);

    // 64-bit, six-source instance
    src384[5*64 +: 64] = 64'h0000_0000_0000_0080;
    sel3 = 3'd5;
    set_ctl(2'd0, 2'b10, 1'b1, 2'd0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("w64_byte_sx", out64, 64'hFFFF_FFFF_FFFF_FF80);
    src384[4*64 +: 64] = 64'h8123_4567_89AB_CDEF;
    sel3 = 3'd4;
    set_ctl(2'd0, 2'b00, 1'b1, 2'd3, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("w64_word", out64, 64'h8123_4567_89AB_CDEF);
    sel3 = 3'd6;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check_val("w64_badsel_data", out64, 64'h0);
    check_val("w64_badsel_err", 64'(e64), 64'h1);

    // random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      rand_in();
      step(1'b0, 32'h0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_data_src_reg.md
Name: wb_data_src_reg

Overview:
- Parametrised, registered successor to the register-file write-back data-source mux.
- Selects one of NUM_SRC data sources, extracts a byte, half or word lane, and sign/zero-extends it to DATA_WIDTH.
- Registers the result with a valid flag and a stall hold.
- Sits between the datapath sources (ALU temp, size handler, PC+4, LO/HI, memory data) and the register file write port.

Parameters:
- DATA_WIDTH, 32, width of each source and of the output; must be >= 32.
- NUM_SRC, 4, number of source channels; must be >= 2.
- SEL_WIDTH, 2, width of sel; must satisfy 2**SEL_WIDTH >= NUM_SRC.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- sel  input  SEL_WIDTH  source index; channel k is src_data[k*DATA_WIDTH +: DATA_WIDTH].
- src_data  input  NUM_SRC*DATA_WIDTH  concatenated source buses.
- size_mode  input  2  00 word, 01 half, 10 byte, 11 reserved.
- sign_ext  input  1  1 = sign-extend the extracted lane, 0 = zero-extend.
- byte_off  input  2  byte offset inside the low 32 bits of the selected source.
- in_valid  input  1  the current inputs form a write-back request.
- stall  input  1  freezes all output registers.
- out_data  output  DATA_WIDTH  registered write-back data.
- out_valid  output  1  registered; out_data is a fresh result this cycle.
- err  output  1  registered; the last accepted request was illegal.

Behaviour:
- Reset (reset low, asynchronous): out_data = 0, out_valid = 0, err = 0 immediately, with no clock needed. Release takes effect at the first rising edge with reset high. Reset mid-request discards that request.
- Latency: 1 cycle. A request accepted at edge N (in_valid=1, stall=0) appears on outputs after edge N, for exactly that cycle unless stalled.
- Priority per edge: reset > stall > in_valid.
  - stall=1: out_data, out_valid and err all hold their values. in_valid is ignored and the request is not captured; upstream must re-present it.
  - stall=0, in_valid=0: out_valid <= 0, err <= 0, out_data holds its previous value.
  - stall=0, in_valid=1: out_valid <= 1, and out_data / err are loaded per the rules below.
- Source select: when sel >= NUM_SRC, the request is illegal: out_data <= 0, err <= 1, out_valid <= 1.
- Lane extraction from w = low 32 bits of the selected source, little-endian lanes:
  - Word: the full DATA_WIDTH source passes unchanged; byte_off and sign_ext are ignored. byte_off != 0 is legal.
  - Half: lane = w[16*byte_off[1] +: 16]. byte_off[0]=1 is misaligned: out_data <= 0, err <= 1.
  - Byte: lane = w[8*byte_off +: 8]; every offset is legal.
  - Extension: the lane MSB (sign_ext=1) or zero (sign_ext=0) fills every bit above the lane up to DATA_WIDTH-1.
  - Reserved mode 11: treated as word, and err <= 1.
- err is evaluated only on accepted requests. Multiple illegal conditions in one request still give a single err=1.
- No combinational path from any input to any output.

Test Plan:
- Reset: hold reset low with random inputs and toggling clk -> out_data=0, out_valid=0, err=0; assert reset asynchronously mid-cycle after a valid result -> all three outputs clear before the next edge.
- Word path (NUM_SRC=4): src1=0xDEADBEEF, sel=1, mode=00, in_valid=1 -> one cycle later out_data=0xDEADBEEF, out_valid=1, err=0; next cycle in_valid=0 -> out_valid=0, out_data stays 0xDEADBEEF.
- Byte/half extension on src0=0x80F17F02:
  - byte, off=1, sign -> 0x0000007F;
  - byte, off=3, sign -> 0xFFFFFF80;
  - half, off=2, zero -> 0x000080F1;
  - half, off=2, sign -> 0xFFFF80F1.
- Illegal requests: NUM_SRC=3, sel=3 -> out_data=0, err=1, out_valid=1; half with off=1 -> out_data=0, err=1; mode=11 on 0x12345678 -> out_data=0x12345678, err=1.
- Stall: valid result 0xA5, then stall=1 for 3 cycles while a new request 0x5A is presented -> outputs frozen at 0xA5 / valid=1; stall released with in_valid=0 -> 0x5A is never output and out_valid=0.
- Parameter sweep: DATA_WIDTH=64, NUM_SRC=6, SEL_WIDTH=3; byte sign-extend of 0x80 from src5 -> out_data=0xFFFFFFFFFFFFFF80; word from src4 passes all 64 bits unchanged.
